// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator-side load/store controller for a single-port
// synchronous word RAM. Byte/halfword/word accesses, read-modify-write for
// sub-word stores, sign/zero-extended loads, rejection of bad addresses.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request; req_ready high
// RD     | ram_read strobe for a load or a sub-word store
// WT     | sample ram_data_out; extract load lane or build merged word
// WR     | ram_write strobe with full or merged word
// RESP   | one-cycle resp_valid, resp_error from the latched check
module mem_access_unit #(
  parameter int unsigned WORDS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic        ram_read,
  output logic        ram_write,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WT   = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state_q, state_d;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = (state_q == S_IDLE) && req_valid;

  // Classify an incoming request as illegal size, misaligned or out of range.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0]) req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= WORDS) req_err = 1'b1;
  end

  // State register; reset abandons any in-flight access with no response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)                                 state_d = S_RESP;
          else if (req_write && req_size == SZ_WORD)   state_d = S_WR;
          else                                         state_d = S_RD;
        end
      end
      S_RD:    state_d = S_WT;
      S_WT:    state_d = write_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture all request fields at the accept edge so later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else if (accept) begin
      write_q  <= req_write;
      size_q   <= req_size;
      signed_q <= req_signed;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      err_q    <= req_err;
    end
  end

  // Pick the addressed byte and halfword lanes out of the returned RAM word.
  always_comb begin
    lane_b = 8'h00;
    case (addr_q[1:0])
      2'd0: lane_b = ram_data_out[7:0];
      2'd1: lane_b = ram_data_out[15:8];
      2'd2: lane_b = ram_data_out[23:16];
      2'd3: lane_b = ram_data_out[31:24];
      default: lane_b = 8'h00;
    endcase
    lane_h = addr_q[1] ? ram_data_out[31:16] : ram_data_out[15:0];
  end

  // Extend the extracted lane to a full load result.
  always_comb begin
    load_val = ram_data_out;
    case (size_q)
      SZ_BYTE: load_val = {{24{signed_q & lane_b[7]}}, lane_b};
      SZ_HALF: load_val = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_val = ram_data_out;
    endcase
  end

  // Overlay the store operand onto the old word for read-modify-write.
  always_comb begin
    merged = ram_data_out;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = ram_data_out;
      endcase
    end else if (size_q == SZ_HALF) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end
  end

  // In WT register either the load result or the merged store word; resp_rdata holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
    end else if (state_q == S_WT) begin
      if (write_q) merge_q <= merged;
      else         rdata_q <= load_val;
    end
  end

  // Strobes and buses decode directly from the state so reset drops them at once.
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    resp_valid  = (state_q == S_RESP);
    resp_error  = (state_q == S_RESP) && err_q;
    resp_rdata  = rdata_q;
    ram_read    = (state_q == S_RD);
    ram_write   = (state_q == S_WR);
    ram_address = 32'h0;
    ram_data_in = 32'h0;
    if (state_q == S_RD || state_q == S_WR) ram_address = {2'b00, addr_q[31:2]};
    if (state_q == S_WR) ram_data_in = (size_q == SZ_WORD) ? wdata_q : merge_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural synchronous RAM.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_address;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;

  logic [31:0] mem [32];

  int n_chk  = 0;
  int n_fail = 0;

  // observations from the most recent request
  int          r_resp, r_rd, r_wr, n_rd, n_wr, r_rdy_busy, r_stray, r_both;
  logic        r_rdy_after;
  logic        r_err;
  logic [31:0] r_rdata, r_wdata, r_waddr, r_raddr;

  always #5 clk = ~clk;

  mem_access_unit #(.WORDS(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_error   (resp_error),
    .resp_rdata   (resp_rdata),
    .ram_read     (ram_read),
    .ram_write    (ram_write),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // single-port RAM with registered read data
  always @(posedge clk) begin
    if (ram_write) mem[ram_address[4:0]] <= ram_data_in;
    if (ram_read)  ram_data_out <= mem[ram_address[4:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    chk("ready_before_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    // scramble inputs to prove they were latched
    req_valid = 1'b0; req_write = ~w; req_size = 2'b11; req_signed = ~sg;
    req_addr = 32'hFFFF_FFFF; req_wdata = ~d;
    r_resp = 0; r_rd = 0; r_wr = 0; n_rd = 0; n_wr = 0; r_rdy_busy = 0;
    r_stray = 0; r_both = 0; r_rdy_after = 1'b0; r_err = 1'bx;
    r_rdata = 'x; r_wdata = 'x; r_waddr = 'x; r_raddr = 'x;
    for (int c = 1; c <= 6; c++) begin
      if (ram_read) begin
        n_rd++;
        if (r_rd == 0) begin r_rd = c; r_raddr = ram_address; end
      end
      if (ram_write) begin
        n_wr++;
        if (r_wr == 0) begin r_wr = c; r_waddr = ram_address; r_wdata = ram_data_in; end
      end
      if (ram_read && ram_write) r_both++;
      if (!ram_read && !ram_write && ram_address != 32'h0) r_stray++;
      if (!ram_write && ram_data_in != 32'h0) r_stray++;
      if (r_resp != 0 && c == r_resp + 1) r_rdy_after = req_ready;
      if (resp_valid && r_resp == 0) begin
        r_resp = c; r_err = resp_error; r_rdata = resp_rdata;
      end
      if (r_resp == 0 && req_ready) r_rdy_busy++;
      if (c < 6) begin @(posedge clk); #1; end
    end
  endtask

  task automatic chk_op(input string tag, input int e_resp, input int e_rd,
                        input int e_wr, input logic e_err);
    chk({tag, "_resp_latency"}, r_resp, e_resp);
    chk({tag, "_resp_error"}, {31'b0, r_err}, {31'b0, e_err});
    chk({tag, "_read_cycle"}, r_rd, e_rd);
    chk({tag, "_write_cycle"}, r_wr, e_wr);
    chk({tag, "_read_pulses"}, n_rd, (e_rd != 0) ? 1 : 0);
    chk({tag, "_write_pulses"}, n_wr, (e_wr != 0) ? 1 : 0);
    chk({tag, "_ready_while_busy"}, r_rdy_busy, 0);
    chk({tag, "_ready_after_resp"}, {31'b0, r_rdy_after}, 32'd1);
    chk({tag, "_idle_buses_zero"}, r_stray, 0);
    chk({tag, "_rd_wr_overlap"}, r_both, 0);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_error", {31'b0, resp_error}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_ram_read", {31'b0, ram_read}, 32'd0);
    chk("rst_ram_write", {31'b0, ram_write}, 32'd0);
    chk("rst_ram_address", ram_address, 32'h0);
    chk("rst_ram_data_in", ram_data_in, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;

    // word store
    run(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk_op("sw", 2, 0, 1, 1'b0);
    chk("sw_addr", r_waddr, 32'd4);
    chk("sw_data", r_wdata, 32'hDEAD_BEEF);

    // word load
    run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk_op("lw", 3, 1, 0, 1'b0);
    chk("lw_addr", r_raddr, 32'd4);
    chk("lw_rdata", r_rdata, 32'hDEAD_BEEF);

    // byte store read-modify-write, only the low byte of wdata used
    run(1'b1, 2'b00, 1'b0, 32'h12, 32'hAAAA_AA55);
    chk_op("sb", 4, 1, 3, 1'b0);
    chk("sb_addr", r_waddr, 32'd4);
    chk("sb_merged", r_wdata, 32'hDE55_BEEF);
    chk("sb_rdata_held", resp_rdata, 32'hDEAD_BEEF);

    run(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    chk_op("lh_s", 3, 1, 0, 1'b0);
    chk("lh_signed", r_rdata, 32'hFFFF_DE55);
    run(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("lh_unsigned", r_rdata, 32'h0000_DE55);
    run(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    chk("lb_signed", r_rdata, 32'hFFFF_FFEF);
    run(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("lbu_top", r_rdata, 32'h0000_00DE);
    run(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    chk("lb_pos", r_rdata, 32'h0000_0055);

    // halfword store to low half
    run(1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF_1234);
    chk_op("sh", 4, 1, 3, 1'b0);
    chk("sh_merged", r_wdata, 32'hDE55_1234);
    run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("sh_readback", r_rdata, 32'hDE55_1234);

    // last valid word
    run(1'b1, 2'b10, 1'b0, 32'h7C, 32'h1234_5678);
    chk_op("sw_last", 2, 0, 1, 1'b0);
    chk("sw_last_addr", r_waddr, 32'd31);
    run(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0);
    chk("lw_last", r_rdata, 32'h1234_5678);

    // rejected accesses: no RAM traffic, rdata unchanged
    run(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
    chk_op("err_lw_mis", 1, 0, 0, 1'b1);
    run(1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF_FFFF);
    chk_op("err_sh_mis", 1, 0, 0, 1'b1);
    run(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    chk_op("err_size", 1, 0, 0, 1'b1);
    run(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    chk_op("err_range", 1, 0, 0, 1'b1);
    chk("err_rdata_held", resp_rdata, 32'h1234_5678);
    run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("after_err_load", r_rdata, 32'hDE55_1234);

    // reset during WR drops the write
    run(1'b1, 2'b10, 1'b0, 32'h20, 32'h1111_1111);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h2222_2222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstwr_in_wr", {31'b0, ram_write}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstwr_write_dropped", {31'b0, ram_write}, 32'd0);
    chk("rstwr_ready", {31'b0, req_ready}, 32'd1);
    chk("rstwr_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("rstwr_data_in", ram_data_in, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rstwr_no_resp_held", {31'b0, resp_valid}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    run(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk_op("rstwr_lw", 3, 1, 0, 1'b0);
    chk("rstwr_old_value", r_rdata, 32'h1111_1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side controller for the single-port synchronous word RAM. It accepts byte, halfword and word load/store requests from the datapath over a valid/ready handshake and turns each one into RAM read and write strobes. Sub-word stores use read-modify-write, and loads are extracted with sign or zero extension. Misaligned or out-of-range accesses are rejected without any RAM traffic. The block sits between the CPU load/store stage and the RAM.

## Interface
- WORDS, 32, RAM depth in 32-bit words; the byte address range is 0 to 4*WORDS-1
- clk  in  1  rising-edge clock, shared with the RAM
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the operand is in the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_error  out  1  qualifies resp_valid: access rejected
- resp_rdata  out  32  load result; valid with resp_valid on a good load
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_address  out  32  word index = {2'b00, latched addr[31:2]}
- ram_data_in  out  32  RAM write data
- ram_data_out  in  32  RAM registered read data; valid the cycle after the ram_read edge

## Operation
- Byte lanes are little-endian: the byte at addr[1:0]=k is bits 8k+7:8k, and the halfword at addr[1]=h is bits 16h+15:16h.
- A request is accepted on an edge where req_valid && req_ready. All request fields are latched at that edge; later changes to the inputs are ignored.
- An accepted request is an error when any of these holds:
  - req_size==11
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:2] >= WORDS
- FSM states are IDLE, RD, WT, WR, RESP. Transitions out of IDLE on accept:
  - error -> RESP
  - word store -> WR
  - any load or sub-word store -> RD
- RD drives ram_read=1. The next state is WT.
- In WT the unit samples ram_data_out:
  - Load: extract the lane, extend it per req_signed, register the result into resp_rdata, then go to RESP.
  - Sub-word store: replace the addressed lane of the sampled word with the low byte or halfword of req_wdata, register the merged word, then go to WR.
- WR drives ram_write=1. ram_data_in is req_wdata for a word store or the merged word for a sub-word store. The next state is RESP.
- RESP drives resp_valid=1 and resp_error per the latched check. The next state is IDLE.
- resp_rdata holds its value until the next good load completes. Stores and errors leave it unchanged.
- ram_read and ram_write are never both high. ram_address is the latched word index in RD and WR and 0 otherwise.
- ram_data_in is 0 outside WR.

## Timing
- Reset values: req_ready=1 (state IDLE), and 0 for resp_valid, resp_error, resp_rdata, ram_read, ram_write, ram_address, ram_data_in.
- Reset asserted mid-operation returns the FSM to IDLE immediately. A pending RAM write is dropped and no response is produced.
- Latency is counted from the accept edge to the cycle in which resp_valid is high:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- req_ready is low from the cycle after accept through RESP. It returns high in the cycle after RESP, so back-to-back requests are spaced by response latency + 1.
- ram_read and ram_write are each a single-cycle pulse per access.
- A read-after-write to the same word returns the new data, because WR completes before the next request is accepted.

## Test plan
- Reset then store word 0xDEADBEEF at addr 0x10. Required: ram_write in one cycle with ram_address=4 and ram_data_in=0xDEADBEEF, then resp_valid 2 cycles after accept with resp_error=0.
- Load word at 0x10. Required: ram_read at 1 cycle after accept, resp_rdata=0xDEADBEEF with resp_valid 3 cycles after accept.
- Store byte 0x55 at 0x12 over 0xDEADBEEF. Required: RD, WT, then WR with ram_data_in=0xDE55BEEF, and resp_valid 4 cycles after accept.
- Signed halfword load at 0x12 of 0xDE55BEEF. Required: resp_rdata=0xFFFFDE55. The same load unsigned returns 0x0000DE55. A signed byte load at 0x10 returns 0xFFFFFFEF.
- Error cases, each requiring resp_valid with resp_error=1 one cycle after accept and no ram_read or ram_write:
  - word load at 0x11
  - halfword store at 0x03
  - req_size=11
  - addr 0x80 with WORDS=32
- Assert reset_n low during WR of a store. Required: ram_write=0 immediately and req_ready=1. Reading the target word afterwards returns its old value.
